usb_tx_serializer: RTL

//  Synthesizable USB 2.0 FS/LS packet transmitter; parametrised successor to the behavioral host line driver.

---
 rtl/usb_pkg.sv | 41 ++++
 rtl/usb_tx_nrzi_stuff.sv | 36 +++
 rtl/usb_tx_serializer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// usb_pkg: shared types for the USB transmit path.
// Line states, FSM encoding, SYNC/PID constants, J/K pin mapping.
package usb_pkg;

  typedef enum logic [1:0] {
    LS_J,
    LS_K,
    LS_SE0
  } line_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SYNC,
    TX_DATA,
    TX_EOP,
    TX_EOPJ,
    TX_IPG
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_SETUP = 8'h2D;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  // Returns {dp, dn}; low speed swaps the J/K polarity, SE0 is shared.
  function automatic logic [1:0] line_pins(line_state_t ls,
                                           logic ls_mode);
    logic [1:0] p;
    case (ls)
      LS_J:    p = ls_mode ? 2'b01 : 2'b10;
      LS_K:    p = ls_mode ? 2'b10 : 2'b01;
      default: p = 2'b00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/usb_tx_nrzi_stuff.sv
// usb_tx_nrzi_stuff: NRZI line level and run-of-ones tracker.
// A stuffed bit is simply a 0 emitted when stuff_o is high.
module usb_tx_nrzi_stuff #(
  parameter int STUFF_LEN = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic emit_i,
  input  logic bit_i,
  output logic level_o,
  output logic stuff_o
);
  localparam int OW = $clog2(STUFF_LEN + 1);

  logic [OW-1:0] ones_q;
  logic          level_q;

  // 0 toggles the level, 1 holds it and extends the run of ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q  <= '0;
      level_q <= 1'b1;
    end else if (emit_i) begin
      level_q <= bit_i ? level_q : !level_q;
      ones_q  <= bit_i ? ones_q + OW'(1) : '0;
    end else if (clr_i) begin
      ones_q  <= '0;
      level_q <= 1'b1;
    end
  end

  assign level_o = level_q;
  assign stuff_o = (ones_q == OW'(STUFF_LEN));

endmodule

// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer: USB FS/LS packet transmitter.
// Byte stream in; SYNC, NRZI stuffed bits, EOP and IPG out on D+/D-.
module usb_tx_serializer
  import usb_pkg::*;
#(
  parameter int CLK_PER_BIT = 4,
  parameter int LS_MODE     = 0,
  parameter int SYNC_BITS   = 8,
  parameter int STUFF_LEN   = 6,
  parameter int EOP_SE0     = 2,
  parameter int IPG_BITS    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_err,
  output logic       dp,
  output logic       dn,
  output logic       oe
);
  localparam int TW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(CLK_PER_BIT - 1);
  localparam logic [7:0] SYNC_LAST = 8'(SYNC_BITS - 1);
  localparam logic [7:0] EOP_LAST  = 8'(EOP_SE0 - 1);
  localparam logic [7:0] IPG_LAST  = 8'(IPG_BITS - 1);

  tx_state_t   state_q, state_d;
  logic [TW-1:0] tmr_q;
  logic [7:0]  cnt_q, cnt_d, hold_q, sh_q;
  logic        hold_full_q, hold_last_q, cur_last_q;
  logic        last_seen_q, discard_q, err_q;
  logic        strobe, accept, store, start;
  logic        reload, shift, underrun, emit, emit_bit;
  logic        level, stuff;
  line_state_t line;

  assign strobe = (state_q != TX_IDLE) && (tmr_q == TMR_LAST);
  assign accept = tx_valid && tx_ready;
  assign store  = accept && !discard_q && !underrun;
  assign start  = store && (state_q == TX_IDLE);

  usb_tx_nrzi_stuff #(.STUFF_LEN(STUFF_LEN)) u_nrzi (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == TX_IDLE),
    .emit_i (emit),
    .bit_i  (emit_bit),
    .level_o(level),
    .stuff_o(stuff)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= TX_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus the per-strobe bit to hand to the encoder.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload   = 1'b0;
    shift    = 1'b0;
    underrun = 1'b0;
    emit     = 1'b0;
    emit_bit = 1'b0;
    unique case (state_q)
      TX_IDLE: if (start) begin
        state_d = TX_SYNC;
        cnt_d   = '0;
        emit    = 1'b1;
      end
      TX_SYNC: if (strobe) begin
        emit = 1'b1;
        if (cnt_q == SYNC_LAST) begin
          state_d  = TX_DATA;
          cnt_d    = '0;
          reload   = 1'b1;
          emit_bit = hold_q[0];
        end else begin
          cnt_d    = cnt_q + 8'd1;
          emit_bit = (cnt_q == SYNC_LAST - 8'd1);
        end
      end
      TX_DATA: if (strobe) begin
        if (stuff) begin
          emit = 1'b1;
        end else if (cnt_q != 8'd7) begin
          emit     = 1'b1;
          shift    = 1'b1;
          emit_bit = sh_q[1];
          cnt_d    = cnt_q + 8'd1;
        end else if (cur_last_q) begin
          state_d = TX_EOP;
          cnt_d   = '0;
        end else if (hold_full_q) begin
          emit     = 1'b1;
          reload   = 1'b1;
          emit_bit = hold_q[0];
          cnt_d    = '0;
        end else begin
          underrun = 1'b1;
          state_d  = TX_EOP;
          cnt_d    = '0;
        end
      end
      TX_EOP: if (strobe) begin
        if (cnt_q == EOP_LAST) begin
          state_d = TX_EOPJ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      TX_EOPJ: if (strobe) begin
        state_d = TX_IPG;
        cnt_d   = '0;
      end
      TX_IPG: if (strobe) begin
        if (cnt_q == IPG_LAST) begin
          state_d = TX_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Symbol timer, holding register, shifter and packet flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q       <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      sh_q        <= '0;
      hold_full_q <= 1'b0;
      hold_last_q <= 1'b0;
      cur_last_q  <= 1'b0;
      last_seen_q <= 1'b0;
      discard_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (state_q == TX_IDLE || strobe) tmr_q <= '0;
      else                              tmr_q <= tmr_q + TW'(1);
      cnt_q <= cnt_d;
      err_q <= underrun;
      if (reload) begin
        sh_q       <= hold_q;
        cur_last_q <= hold_last_q;
      end else if (shift) begin
        sh_q <= {1'b0, sh_q[7:1]};
      end
      if (store) begin
        hold_q      <= tx_data;
        hold_last_q <= tx_last;
        hold_full_q <= 1'b1;
      end else if (reload) begin
        hold_full_q <= 1'b0;
      end
      if (store && tx_last)
        last_seen_q <= 1'b1;
      else if (state_q == TX_IPG && state_d == TX_IDLE)
        last_seen_q <= 1'b0;
      if (underrun || discard_q)
        discard_q <= !(accept && tx_last);
    end
  end

  // Line state, pin mapping and handshake outputs.
  always_comb begin
    line = LS_J;
    oe   = 1'b0;
    unique case (state_q)
      TX_SYNC, TX_DATA: begin
        line = level ? LS_J : LS_K;
        oe   = 1'b1;
      end
      TX_EOP: begin
        line = LS_SE0;
        oe   = 1'b1;
      end
      TX_EOPJ: oe = 1'b1;
      default: ;
    endcase
    {dp, dn} = line_pins(line, LS_MODE != 0);
    tx_busy  = (state_q != TX_IDLE);
    tx_err   = err_q;
    tx_ready = (state_q != TX_IPG) &&
               (discard_q || (!hold_full_q && !last_seen_q));
  end

endmodule
